bit_controller: RTL and testbench
=================================

# bit_controller

Parametrised one-bit industrial control processor executing the 16-opcode MC14500B instruction set. It is the next generation of the team's `processor` top: it adds a handshake program loader, a run/idle/fault state machine, a JMP/RTN return-address stack, true RTN and SKZ skip semantics, and scratch bits. It sits between a host that downloads programs and the I/O pin banks of the controlled plant.

## Interface
- `ADDR`, 8: program and data address width; program memory depth is 2^ADDR words.
- `INPUT`, 5: number of input pins.
- `OUTPUT`, 5: number of output pins.
- `SCRATCH`, 8: number of internal read/write scratch bits.
- `STACK`, 4: return-stack depth, minimum 1.
- Instruction word: 4-bit opcode in bits [ADDR+3:ADDR], address in bits [ADDR-1:0].
- Constraint: `INPUT+OUTPUT+SCRATCH <= 2^ADDR-1`.

Ports:
- `clk` in 1: the single clock, rising edge.
- `reset` in 1: synchronous, active-high. This is already decided.
- `load_valid` in 1: host offers a program word.
- `load_ready` out 1: loader accepts the word; high only in IDLE.
- `load_addr` in ADDR: program address of the offered word.
- `load_data` in ADDR+4: program word.
- `run` in 1: level request to execute.
- `input_pins` in INPUT: plant inputs, already synchronised by the host.
- `output_pins` out OUTPUT: output latches.
- `pc` out ADDR: current program counter.
- `running` out 1: state is RUN.
- `fault` out 1: state is FAULT.
- `flag_o` out 1: one-cycle pulse after a NOPO executes.
- `flag_f` out 1: one-cycle pulse after a NOPF executes.

## Operation
- Data map, used for reads and STO:
  - Addresses 0..INPUT-1 are inputs; writes to them are ignored.
  - The next OUTPUT addresses are the output latches; reads return the latch value.
  - The next SCRATCH addresses are the scratch bits.
  - Address all-ones reads RR.
  - Any other address reads 0 and ignores writes.
- States:
  - IDLE: on reset. A transfer happens when `load_valid` and `load_ready` are both high. `run` high moves to RUN with PC=0, RR=0, IEN=1, OEN=1, skip=0 and the stack emptied.
  - RUN: one instruction per clock. If `run` is low at an edge, that edge executes nothing and returns to IDLE. Outputs and scratch are kept.
  - FAULT: entered on stack overflow or underflow. The faulting instruction has no other effect. Only `reset` leaves FAULT.
- Effective data D is the data-map read when IEN=1, otherwise 0.
- Opcodes:
  - 0 NOPO: pulse `flag_o`.
  - 1 LD: RR=D.
  - 2 LDC: RR=!D.
  - 3 AND: RR&=D.
  - 4 ANDC: RR&=!D.
  - 5 OR: RR|=D.
  - 6 ORC: RR|=!D.
  - 7 XNOR: RR=(RR==D).
  - 8 STO: write RR to the address if OEN=1.
  - 9 STOC: write !RR to the address if OEN=1.
  - A IEN: IEN=raw read, ungated.
  - B OEN: OEN=raw read, ungated.
  - C JMP: push PC+1 and set PC=address. If the stack is full, go to FAULT.
  - D RTN: pop into PC and set skip=1. If the stack is empty, go to FAULT.
  - E SKZ: if RR=0, set skip=1.
  - F NOPF: pulse `flag_f`.
- Skip: when skip=1, the next instruction is fetched and discarded as a NOP and skip is cleared. A skipped JMP, RTN or SKZ has no effect.
- PC increments modulo 2^ADDR; 2^ADDR-1 wraps to 0.
- Program memory keeps its contents through `reset`.

## Timing
- Reset values: `output_pins`=0, `pc`=0, `running`=0, `fault`=0, `flag_o`=0, `flag_f`=0, `load_ready`=1 in the cycle after reset; RR=0, IEN=1, OEN=1, scratch=0, stack empty.
- Program memory is read asynchronously at `pc`. Each instruction completes at one rising edge: RR, `output_pins`, scratch, PC and stack all update at that edge.
- Inputs are sampled combinationally at the executing edge.
- Start latency: the edge that sees `run`=1 in IDLE enters RUN. The instruction at address 0 executes on the following edge.
- `flag_o` and `flag_f` are registered. They are high for exactly the cycle after the executing edge.
- Load and run on the same edge in IDLE: the write is performed and RUN is entered. The written word is visible to the first fetch.
- `load_valid` in RUN or FAULT is not accepted; `load_ready`=0.
- `reset` has priority over everything. Mid-run it returns to IDLE with the reset values above.
- STO to address all-ones or to an input address has no effect.

## Test plan
- Load `{1,0x00},{8,0x05},{C,0x00}` with INPUT=5, then run. Toggle `input_pins[0]`: `output_pins[0]` follows it one instruction later; `pc` cycles 0,1,2,0.
- Run `{B,0x05}` with output 0 = 0, so OEN becomes 0, then `{2,0x00}`, `{8,0x05}`: `output_pins` stays 0.
- Run a program with STACK=2 and three nested JMPs without RTN: `fault`=1 after the third JMP, `pc` frozen, `running`=0.
- Run JMP 0x10, where 0x10 holds RTN: `pc` returns to 1. The instruction at 1 (STO) is skipped and the instruction at 2 executes.
- Run `{2,0xFF}` (RR=!RR=1, since RR starts at 0), then `{E,0}`, then `{0,0}`: `flag_o` is high for one cycle. Repeat with RR=0: NOPO is skipped and `flag_o` stays 0.
- Assert `reset` mid-run with outputs at 0b10101: the next cycle shows `output_pins`=0, `pc`=0, `load_ready`=1, and program memory is intact when rerun.

Source files
------------

// File: rtl/bit_controller_if.sv
// Program-loader handshake between the host and bit_controller.
// Ports: valid/addr/data driven by the host (master), ready returned by the
// controller (slave). A word transfers when valid and ready are both high.
interface bit_controller_if #(
    parameter int unsigned ADDR = 8
) ();
    logic            valid;
    logic            ready;
    logic [ADDR-1:0] addr;
    logic [ADDR+3:0] data;

    modport master (
        output valid,
        output addr,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  addr,
        input  data,
        output ready
    );
endinterface

// File: rtl/bit_controller.sv
// One-bit industrial control processor running the MC14500B instruction set,
// with a handshake program loader, an IDLE/RUN/FAULT state machine, a JMP/RTN
// return stack, skip semantics and internal scratch bits.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   load (slave)        program loader handshake (valid/ready/addr/data)
//   run                 level request to execute
//   input_pins          plant inputs (already synchronised)
//   output_pins         output latches
//   pc                  program counter
//   running, fault      state indicators
//   flag_o, flag_f      one-cycle pulses after NOPO / NOPF execute
module bit_controller #(
    parameter int unsigned ADDR    = 8,
    parameter int unsigned INPUT   = 5,
    parameter int unsigned OUTPUT  = 5,
    parameter int unsigned SCRATCH = 8,
    parameter int unsigned STACK   = 4
) (
    input  logic                clk,
    input  logic                reset,
    bit_controller_if.slave     load,
    input  logic                run,
    input  logic [INPUT-1:0]    input_pins,
    output logic [OUTPUT-1:0]   output_pins,
    output logic [ADDR-1:0]     pc,
    output logic                running,
    output logic                fault,
    output logic                flag_o,
    output logic                flag_f
);
    localparam int unsigned WORD_W   = ADDR + 4;
    localparam int unsigned DEPTH    = 1 << ADDR;
    localparam int unsigned SP_W     = $clog2(STACK + 1);
    localparam int unsigned OUT_BASE = INPUT;
    localparam int unsigned SCR_BASE = INPUT + OUTPUT;

    localparam logic [3:0] OP_NOPO = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_LDC  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_ANDC = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_ORC  = 4'h6;
    localparam logic [3:0] OP_XNOR = 4'h7;
    localparam logic [3:0] OP_STO  = 4'h8;
    localparam logic [3:0] OP_STOC = 4'h9;
    localparam logic [3:0] OP_IEN  = 4'hA;
    localparam logic [3:0] OP_OEN  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_RTN  = 4'hD;
    localparam logic [3:0] OP_SKZ  = 4'hE;
    localparam logic [3:0] OP_NOPF = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  mem [DEPTH];
    logic [WORD_W-1:0]  instr_c;
    logic [3:0]         opcode_c;
    logic [ADDR-1:0]    operand_c;
    logic               rd_raw_c, rd_eff_c, st_val_c;
    logic               exec_c, stack_err_c, accept_c;
    logic               rr_q, rr_d, ien_q, ien_d, oen_q, oen_d, skip_q, skip_d;
    logic [ADDR-1:0]    pc_d;
    logic [SP_W-1:0]    sp_q, sp_d;
    logic [ADDR-1:0]    stack_q [STACK];
    logic [ADDR-1:0]    stack_d [STACK];
    logic [OUTPUT-1:0]  out_d;
    logic [SCRATCH-1:0] scr_q, scr_d;
    logic               ready_q;
    logic               flag_o_d, flag_f_d;

    assign load.ready = ready_q;
    assign accept_c   = load.valid && ready_q;

    // Asynchronous fetch at the current pc.
    assign instr_c   = mem[pc];
    assign opcode_c  = instr_c[ADDR+3:ADDR];
    assign operand_c = instr_c[ADDR-1:0];

    // An instruction executes only in RUN with run held and no pending skip.
    assign exec_c   = (state_q == ST_RUN) && run && !skip_q;
    assign rd_eff_c = ien_q & rd_raw_c;
    assign st_val_c = (opcode_c == OP_STO) ? rr_q : !rr_q;

    assign stack_err_c = exec_c &&
        (((opcode_c == OP_JMP) && (sp_q == SP_W'(STACK))) ||
         ((opcode_c == OP_RTN) && (sp_q == '0)));

    // Data-map read: inputs, output latches, scratch, RR at all-ones, else 0.
    always_comb begin : data_read
        rd_raw_c = 1'b0;
        for (int unsigned i = 0; i < INPUT; i++)
            if (operand_c == ADDR'(i)) rd_raw_c = input_pins[i];
        for (int unsigned j = 0; j < OUTPUT; j++)
            if (operand_c == ADDR'(OUT_BASE + j)) rd_raw_c = output_pins[j];
        for (int unsigned k = 0; k < SCRATCH; k++)
            if (operand_c == ADDR'(SCR_BASE + k)) rd_raw_c = scr_q[k];
        if (operand_c == '1) rd_raw_c = rr_q;
    end

    // State register.
    always_ff @(posedge clk) begin : state_reg
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (run) state_d = ST_RUN;
            ST_RUN: begin
                if (!run)             state_d = ST_IDLE;
                else if (stack_err_c) state_d = ST_FAULT;
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; a faulting instruction changes nothing.
    always_comb begin : datapath_next
        rr_d     = rr_q;
        ien_d    = ien_q;
        oen_d    = oen_q;
        skip_d   = skip_q;
        pc_d     = pc;
        sp_d     = sp_q;
        stack_d  = stack_q;
        out_d    = output_pins;
        scr_d    = scr_q;
        flag_o_d = 1'b0;
        flag_f_d = 1'b0;
        if ((state_q == ST_IDLE) && run) begin
            rr_d   = 1'b0;
            ien_d  = 1'b1;
            oen_d  = 1'b1;
            skip_d = 1'b0;
            pc_d   = '0;
            sp_d   = '0;
        end else if ((state_q == ST_RUN) && run) begin
            if (skip_q) begin
                skip_d = 1'b0;
                pc_d   = pc + ADDR'(1);
            end else if (!stack_err_c) begin
                pc_d = pc + ADDR'(1);
                case (opcode_c)
                    OP_NOPO: flag_o_d = 1'b1;
                    OP_LD:   rr_d = rd_eff_c;
                    OP_LDC:  rr_d = !rd_eff_c;
                    OP_AND:  rr_d = rr_q & rd_eff_c;
                    OP_ANDC: rr_d = rr_q & !rd_eff_c;
                    OP_OR:   rr_d = rr_q | rd_eff_c;
                    OP_ORC:  rr_d = rr_q | !rd_eff_c;
                    OP_XNOR: rr_d = (rr_q == rd_eff_c);
                    OP_STO, OP_STOC: begin
                        if (oen_q) begin
                            for (int unsigned j = 0; j < OUTPUT; j++)
                                if (operand_c == ADDR'(OUT_BASE + j)) out_d[j] = st_val_c;
                            for (int unsigned k = 0; k < SCRATCH; k++)
                                if (operand_c == ADDR'(SCR_BASE + k)) scr_d[k] = st_val_c;
                        end
                    end
                    OP_IEN:  ien_d = rd_raw_c;
                    OP_OEN:  oen_d = rd_raw_c;
                    OP_JMP: begin
                        for (int unsigned s = 0; s < STACK; s++)
                            if (sp_q == SP_W'(s)) stack_d[s] = pc + ADDR'(1);
                        sp_d = sp_q + SP_W'(1);
                        pc_d = operand_c;
                    end
                    OP_RTN: begin
                        for (int unsigned s = 0; s < STACK; s++)
                            if (sp_q == SP_W'(s + 1)) pc_d = stack_q[s];
                        sp_d   = sp_q - SP_W'(1);
                        skip_d = 1'b1;
                    end
                    OP_SKZ:  if (!rr_q) skip_d = 1'b1;
                    OP_NOPF: flag_f_d = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin : datapath_reg
        if (reset) begin
            rr_q        <= 1'b0;
            ien_q       <= 1'b1;
            oen_q       <= 1'b1;
            skip_q      <= 1'b0;
            pc          <= '0;
            sp_q        <= '0;
            for (int unsigned s = 0; s < STACK; s++) stack_q[s] <= '0;
            output_pins <= '0;
            scr_q       <= '0;
            flag_o      <= 1'b0;
            flag_f      <= 1'b0;
            ready_q     <= 1'b1;
            running     <= 1'b0;
            fault       <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            ien_q       <= ien_d;
            oen_q       <= oen_d;
            skip_q      <= skip_d;
            pc          <= pc_d;
            sp_q        <= sp_d;
            stack_q     <= stack_d;
            output_pins <= out_d;
            scr_q       <= scr_d;
            flag_o      <= flag_o_d;
            flag_f      <= flag_f_d;
            ready_q     <= (state_d == ST_IDLE);
            running     <= (state_d == ST_RUN);
            fault       <= (state_d == ST_FAULT);
        end
    end

    // Program memory survives reset; reset still blocks a same-edge write.
    always_ff @(posedge clk) begin : program_mem
        if (!reset && accept_c) mem[load.addr] <= load.data;
    end
endmodule

// File: tb/tb_bit_controller.sv
// Self-checking bench for bit_controller: directed scenarios plus randomized
// programs, compared every cycle against a behavioural instruction-level model.
module tb_bit_controller;
    localparam int NI  = 5;
    localparam int NO  = 5;
    localparam int NS  = 8;
    localparam int STK = 2;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_FAULT = 2;

    logic        clk;
    logic        reset;
    logic        run;
    logic [4:0]  pins;
    logic [4:0]  output_pins;
    logic [7:0]  pc;
    logic        running, fault, flag_o, flag_f;

    bit_controller_if #(.ADDR(8)) lif ();

    bit_controller #(
        .ADDR(8), .INPUT(NI), .OUTPUT(NO), .SCRATCH(NS), .STACK(STK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (lif),
        .run        (run),
        .input_pins (pins),
        .output_pins(output_pins),
        .pc         (pc),
        .running    (running),
        .fault      (fault),
        .flag_o     (flag_o),
        .flag_f     (flag_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: instruction-level semantics with a queue stack.
    bit [11:0] m_mem [256];
    int        m_state;
    bit        m_rr, m_ien, m_oen, m_skip, m_fo, m_ff;
    bit [7:0]  m_pc;
    bit [4:0]  m_out;
    bit [7:0]  m_scr;
    bit [7:0]  m_stack [$];

    function automatic bit m_read(input int a);
        if (a < NI) return pins[a];
        if (a < NI + NO) return m_out[a - NI];
        if (a < NI + NO + NS) return m_scr[a - NI - NO];
        if (a == 255) return m_rr;
        return 1'b0;
    endfunction

    task automatic m_write(input int a, input bit v);
        if (a >= NI && a < NI + NO) m_out[a - NI] = v;
        else if (a >= NI + NO && a < NI + NO + NS) m_scr[a - NI - NO] = v;
    endtask

    task automatic model_step();
        bit [11:0] word;
        int op, a;
        bit d;
        m_fo = 1'b0;
        m_ff = 1'b0;
        if (reset) begin
            m_state = S_IDLE; m_rr = 0; m_ien = 1; m_oen = 1; m_skip = 0;
            m_pc = 0; m_out = 0; m_scr = 0; m_stack.delete();
            return;
        end
        if (m_state == S_IDLE) begin
            if (lif.valid) m_mem[lif.addr] = lif.data;
            if (run) begin
                m_state = S_RUN; m_pc = 0; m_rr = 0; m_ien = 1; m_oen = 1;
                m_skip = 0; m_stack.delete();
            end
        end else if (m_state == S_RUN) begin
            if (!run) m_state = S_IDLE;
            else if (m_skip) begin
                m_skip = 0;
                m_pc = m_pc + 8'd1;
            end else begin
                word = m_mem[m_pc];
                op = int'(word[11:8]);
                a  = int'(word[7:0]);
                d  = m_ien ? m_read(a) : 1'b0;
                case (op)
                    0:  m_fo = 1;
                    1:  m_rr = d;
                    2:  m_rr = !d;
                    3:  m_rr = m_rr && d;
                    4:  m_rr = m_rr && !d;
                    5:  m_rr = m_rr || d;
                    6:  m_rr = m_rr || !d;
                    7:  m_rr = (m_rr == d);
                    8:  if (m_oen) m_write(a, m_rr);
                    9:  if (m_oen) m_write(a, !m_rr);
                    10: m_ien = m_read(a);
                    11: m_oen = m_read(a);
                    14: if (!m_rr) m_skip = 1;
                    15: m_ff = 1;
                    default: ;
                endcase
                if (op == 12) begin
                    if (m_stack.size() == STK) m_state = S_FAULT;
                    else begin
                        m_stack.push_back(m_pc + 8'd1);
                        m_pc = 8'(a);
                    end
                end else if (op == 13) begin
                    if (m_stack.size() == 0) m_state = S_FAULT;
                    else begin
                        m_pc = m_stack.pop_back();
                        m_skip = 1;
                    end
                end else begin
                    m_pc = m_pc + 8'd1;
                end
            end
        end
    endtask

    task automatic compare_all();
        check_eq("output_pins", 32'(output_pins), 32'(m_out));
        check_eq("pc",          32'(pc),          32'(m_pc));
        check_eq("running",     32'(running),     32'(m_state == S_RUN));
        check_eq("fault",       32'(fault),       32'(m_state == S_FAULT));
        check_eq("flag_o",      32'(flag_o),      32'(m_fo));
        check_eq("flag_f",      32'(flag_f),      32'(m_ff));
        check_eq("load_ready",  32'(lif.ready),   32'(m_state == S_IDLE));
    endtask

    task automatic cycle(input bit r, input bit rn, input bit lv,
                         input bit [7:0] la, input bit [11:0] ld, input bit [4:0] p);
        @(negedge clk);
        reset = r; run = rn; lif.valid = lv; lif.addr = la; lif.data = ld; pins = p;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    function automatic bit [11:0] w(input int op, input int a);
        bit [3:0] o = 4'(op);
        bit [7:0] d = 8'(a);
        return {o, d};
    endfunction

    function automatic bit [11:0] rand_word();
        int op = int'($urandom_range(0, 15));
        int a;
        if (op == 12) a = int'($urandom_range(0, 255));
        else if ($urandom_range(0, 4) == 0) a = 255;
        else a = int'($urandom_range(0, 20));
        return w(op, a);
    endfunction

    task automatic do_reset();
        cycle(1, 0, 0, 8'h00, 12'h000, 5'h00);
    endtask

    task automatic load_word(input int a, input bit [11:0] word);
        cycle(0, 0, 1, 8'(a), word, 5'h00);
    endtask

    task automatic step(input bit rn, input bit [4:0] p);
        cycle(0, rn, 0, 8'h00, 12'h000, p);
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; pins = '0;
        lif.valid = 1'b0; lif.addr = '0; lif.data = '0;

        // Reset state.
        do_reset();
        check_eq("rst_out",   32'(output_pins), 32'h0);
        check_eq("rst_pc",    32'(pc),          32'h0);
        check_eq("rst_ready", 32'(lif.ready),   32'h1);
        check_eq("rst_run",   32'(running),     32'h0);
        check_eq("rst_fault", 32'(fault),       32'h0);

        // Fill the whole program memory so every fetch is defined.
        for (int i = 0; i < 256; i++) load_word(i, rand_word());

        // Input follows to output; pc cycles 0,1,2,0.
        do_reset();
        load_word(0, w(1, 0)); load_word(1, w(8, 5)); load_word(2, w(12, 0));
        step(1, 5'h01);
        check_eq("t1_enter_pc", 32'(pc), 32'h0);
        step(1, 5'h01); check_eq("t1_pc1", 32'(pc), 32'h1);
        step(1, 5'h01); check_eq("t1_pc2", 32'(pc), 32'h2);
        check_eq("t1_out_hi", 32'(output_pins[0]), 32'h1);
        step(1, 5'h00); check_eq("t1_pc0", 32'(pc), 32'h0);
        step(1, 5'h00);
        step(1, 5'h00);
        check_eq("t1_out_lo", 32'(output_pins[0]), 32'h0);
        step(1, 5'h00);
        step(0, 5'h00);
        check_eq("t1_idle", 32'(running), 32'h0);

        // OEN cleared blocks stores.
        do_reset();
        load_word(0, w(11, 5)); load_word(1, w(2, 0)); load_word(2, w(8, 5));
        step(1, 5'h00);
        repeat (3) step(1, 5'h00);
        check_eq("t2_oen_out", 32'(output_pins), 32'h0);
        step(0, 5'h00);

        // Stack overflow with three nested JMPs.
        do_reset();
        load_word(0, w(12, 1)); load_word(1, w(12, 2)); load_word(2, w(12, 3));
        step(1, 5'h00);
        repeat (3) step(1, 5'h00);
        check_eq("t3_fault",   32'(fault),   32'h1);
        check_eq("t3_running", 32'(running), 32'h0);
        check_eq("t3_pc",      32'(pc),      32'h2);
        step(1, 5'h00);
        check_eq("t3_pc_frozen", 32'(pc), 32'h2);
        check_eq("t3_ready",     32'(lif.ready), 32'h0);

        // JMP/RTN: return to 1, skip it, execute 2.
        do_reset();
        load_word(0, w(12, 16)); load_word(1, w(9, 5)); load_word(2, w(9, 6));
        load_word(16, w(13, 0));
        step(1, 5'h00);
        step(1, 5'h00); check_eq("t4_pc_jmp", 32'(pc), 32'h10);
        step(1, 5'h00); check_eq("t4_pc_rtn", 32'(pc), 32'h1);
        step(1, 5'h00);
        step(1, 5'h00);
        check_eq("t4_out", 32'(output_pins), 32'h02);
        check_eq("t4_pc3", 32'(pc), 32'h3);
        step(0, 5'h00);

        // SKZ with RR=1 then RR=0 around a NOPO.
        do_reset();
        load_word(0, w(2, 255)); load_word(1, w(14, 0)); load_word(2, w(0, 0));
        load_word(3, w(1, 0));
        step(1, 5'h00);
        repeat (3) step(1, 5'h00);
        check_eq("t5_flag_o_hi", 32'(flag_o), 32'h1);
        step(1, 5'h00);
        check_eq("t5_flag_o_pulse", 32'(flag_o), 32'h0);
        step(0, 5'h00);
        do_reset();
        load_word(0, w(1, 18));
        step(1, 5'h00);
        repeat (3) step(1, 5'h00);
        check_eq("t5_skip_flag_o", 32'(flag_o), 32'h0);
        step(1, 5'h00);
        check_eq("t5_skip_flag_o2", 32'(flag_o), 32'h0);
        step(0, 5'h00);

        // Reset mid-run with outputs 0b10101; memory survives.
        do_reset();
        load_word(0, w(2, 255)); load_word(1, w(8, 5)); load_word(2, w(8, 7));
        load_word(3, w(8, 9)); load_word(4, w(1, 0));
        step(1, 5'h00);
        repeat (4) step(1, 5'h00);
        check_eq("t6_out", 32'(output_pins), 32'h15);
        cycle(1, 1, 0, 8'h00, 12'h000, 5'h00);
        check_eq("t6_rst_out",   32'(output_pins), 32'h0);
        check_eq("t6_rst_pc",    32'(pc),          32'h0);
        check_eq("t6_rst_ready", 32'(lif.ready),   32'h1);
        step(1, 5'h00);
        repeat (4) step(1, 5'h00);
        check_eq("t6_rerun_out", 32'(output_pins), 32'h15);

        // Randomized episodes.
        for (int e = 0; e < 40; e++) begin
            do_reset();
            repeat ($urandom_range(0, 8))
                load_word(int'($urandom_range(0, 255)), rand_word());
            for (int c = 0; c < 120; c++) begin
                cycle(0, ($urandom_range(0, 15) != 0), ($urandom_range(0, 3) == 0),
                      8'($urandom), rand_word(), 5'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
